// File: rtl/apb_reg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : apb_reg_decoder
// Brief    : APB3 completer that turns each transfer into one-hot register-cell
//            strobes with a fixed two-wait-state response. Optional macro
//            APB_REG_DECODER_PPROT_EN adds pprot and rejects unprivileged writes.
// Revision : 1.0  initial release
// ============================================================================
module apb_reg_decoder #(
  parameter int NREG = 12,
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [AW-1:0]        paddr,
  input  logic [DW-1:0]        pwdata,
`ifdef APB_REG_DECODER_PPROT_EN
  input  logic [2:0]           pprot,
`endif
  output logic [DW-1:0]        prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [NREG-1:0]      read,
  output logic [NREG-1:0]      write,
  output logic [DW-1:0]        wdata,
  input  logic [NREG*DW-1:0]   rdata_bus
);

  localparam int            c_nbytes = DW / 8;
  localparam int            c_ob     = $clog2(c_nbytes);
  localparam int            c_iw     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] c_base   = AW'(BASE);
  localparam logic [AW-1:0] c_mask   = AW'(c_nbytes - 1);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_strobe  = 2'd1;
  localparam logic [1:0] c_capture = 2'd2;
  localparam logic [1:0] c_resp    = 2'd3;

  logic [1:0]      r_state;
  logic [c_iw-1:0] r_idx;
  logic            r_err;
  logic            r_wr;

  logic [AW-1:0]   w_off;
  logic [AW-1:0]   w_idx;
  logic            w_deny;
  logic            w_err;
  logic [NREG-1:0] w_onehot;
  logic [DW-1:0]   w_rsel;

  assign w_off    = paddr - c_base;
  assign w_idx    = w_off >> c_ob;
  assign w_onehot = NREG'(1) << w_idx;

`ifdef APB_REG_DECODER_PPROT_EN
  // Only pprot[0] (privileged) matters; the other bits are accepted and ignored.
  logic w_unused_pprot;
  assign w_unused_pprot = ^pprot[2:1];
  assign w_deny         = pwrite & ~pprot[0];
`else
  assign w_deny = 1'b0;
`endif

  assign w_err = (|(w_off & c_mask)) | (paddr < c_base)
               | (32'(w_idx) >= 32'(NREG)) | w_deny;

  // An out-of-range r_idx only occurs with r_err set, where the slice is discarded.
  assign w_rsel = rdata_bus[32'(r_idx)*DW +: DW];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= c_idle;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
      read    <= '0;
      write   <= '0;
      wdata   <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      read    <= '0;
      write   <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (r_state)
        c_idle: begin
          // Strobes are launched on the setup edge so they are visible in STROBE.
          if (psel && !penable) begin
            r_idx   <= w_idx[c_iw-1:0];
            r_err   <= w_err;
            r_wr    <= pwrite;
            r_state <= c_strobe;
            if (!w_err) begin
              read  <= pwrite ? '0 : w_onehot;
              write <= pwrite ? w_onehot : '0;
              wdata <= pwdata;
            end
          end
        end
        c_strobe: begin
          r_state <= psel ? c_capture : c_idle;
        end
        c_capture: begin
          if (!psel) begin
            r_state <= c_idle;
          end else begin
            if (!r_wr) begin
              prdata <= r_err ? '0 : w_rsel;
            end
            pready  <= 1'b1;
            pslverr <= r_err;
            r_state <= c_resp;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
